// File: rtl/serial_word_rx.sv
// Serial-to-parallel word receiver: frames of WIDTH bits (LSB- or MSB-first) into a one-word valid/ready holding register.
// Optional even-parity bit per frame when SERIAL_WORD_RX_PARITY_EN is defined (adds PAR state and parity_err port).
module serial_word_rx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin_valid,
  input  logic             sin,
  input  logic             sof,
  input  logic             dir,
  input  logic             out_ready,
  input  logic             clr_ovf,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             overflow,
`ifdef SERIAL_WORD_RX_PARITY_EN
  output logic             parity_err,
`endif
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SERIAL_WORD_RX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic             dir_q, dir_n;
  logic             done, done_n;
  logic             ferr_n;
  logic             perr_n;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sreg_n  = sreg;
    dir_n   = dir_q;
    done_n  = 1'b0;
    ferr_n  = 1'b0;
    perr_n  = 1'b0;
    if (sin_valid) begin
      if (sof) begin
        // A sof always starts a fresh frame; mid-frame it aborts the old one.
        ferr_n  = (state != IDLE);
        dir_n   = dir;
        cnt_n   = CW'(1);
        state_n = SHIFT;
        sreg_n  = dir ? {{(WIDTH-1){1'b0}}, sin} : {sin, {(WIDTH-1){1'b0}}};
      end else begin
        case (state)
          SHIFT: begin
            sreg_n = dir_q ? {sreg[WIDTH-2:0], sin} : {sin, sreg[WIDTH-1:1]};
            if (cnt == LAST) begin
`ifdef SERIAL_WORD_RX_PARITY_EN
              state_n = PAR;
              cnt_n   = CW'(WIDTH);
`else
              state_n = IDLE;
              cnt_n   = '0;
              done_n  = 1'b1;
`endif
            end else begin
              cnt_n = cnt + CW'(1);
            end
          end
`ifdef SERIAL_WORD_RX_PARITY_EN
          PAR: begin
            state_n = IDLE;
            cnt_n   = '0;
            if (sin == ^sreg) done_n = 1'b1;
            else              perr_n = 1'b1;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sreg      <= '0;
      dir_q     <= 1'b0;
      done      <= 1'b0;
      frame_err <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sreg      <= sreg_n;
      dir_q     <= dir_n;
      done      <= done_n;
      frame_err <= ferr_n;
      // done means sreg holds the word completed on the previous edge.
      if (done && (!out_valid || out_ready)) begin
        out_data  <= sreg;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (done && out_valid && !out_ready) overflow <= 1'b1;
      else if (clr_ovf)                    overflow <= 1'b0;
    end
  end

`ifdef SERIAL_WORD_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= perr_n;
  end
`else
  logic unused_perr;
  assign unused_perr = perr_n;
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_word_rx.sv
// Randomized scoreboard bench for serial_word_rx against a frame-level reference model.
module tb_serial_word_rx;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sin_valid = 1'b0, sin = 1'b0, sof = 1'b0, dir = 1'b0;
  logic         out_ready = 1'b0, clr_ovf = 1'b0;
  logic         out_valid, busy, overflow, frame_err;
  logic [W-1:0] out_data;
`ifdef SERIAL_WORD_RX_PARITY_EN
  logic         parity_err;
`endif

  serial_word_rx #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .sin_valid(sin_valid), .sin(sin), .sof(sof), .dir(dir),
    .out_ready(out_ready), .clr_ovf(clr_ovf), .out_valid(out_valid), .out_data(out_data),
    .busy(busy), .overflow(overflow),
`ifdef SERIAL_WORD_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic mon_en = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frames as bit lists, words built by positional arithmetic.
  logic [W-1:0] exp_q[$];
  bit           bits[$];
  bit           m_dir, m_ov, m_ovf, m_ferr, m_pend, m_pwait, m_perr;
  logic [W-1:0] m_word;

  function automatic logic [W-1:0] assemble(bit q[$], bit d);
    logic [W-1:0] w = '0;
    for (int i = 0; i < W; i++)
      if (d) w[W-1-i] = q[i]; else w[i] = q[i];
    return w;
  endfunction

  always @(posedge clk) begin
    bit ld, setovf;
    ld = 0; setovf = 0;
    if (rst) begin
      exp_q.delete(); bits.delete();
      m_dir = 0; m_ov = 0; m_ovf = 0; m_ferr = 0; m_pend = 0; m_pwait = 0; m_perr = 0;
    end else begin
      if (m_pend) begin
        if (!m_ov || out_ready) begin exp_q.push_back(m_word); ld = 1; end
        else setovf = 1;
      end
      if (m_ov && out_ready && !ld) m_ov = 0;
      if (ld) m_ov = 1;
      if (setovf) m_ovf = 1; else if (clr_ovf) m_ovf = 0;
      m_pend = 0; m_ferr = 0; m_perr = 0;
      if (sin_valid) begin
        if (sof) begin
          m_ferr = (bits.size() > 0) || m_pwait;
          m_pwait = 0;
          bits.delete(); bits.push_back(sin);
          m_dir = dir;
        end else if (m_pwait) begin
          m_pwait = 0;
          if (sin == ^m_word) m_pend = 1; else m_perr = 1;
        end else if (bits.size() > 0) begin
          bits.push_back(sin);
        end
        if (bits.size() == W) begin
          m_word = assemble(bits, m_dir);
          bits.delete();
`ifdef SERIAL_WORD_RX_PARITY_EN
          m_pwait = 1;
`else
          m_pend = 1;
`endif
        end
      end
    end
  end

  // Monitor: samples mid-cycle; a transfer happens at the next edge if valid&&ready.
  always @(negedge clk) if (mon_en) begin
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("busy", 32'(busy), 32'((bits.size() > 0) || m_pwait));
    check("frame_err", 32'(frame_err), 32'(m_ferr));
`ifdef SERIAL_WORD_RX_PARITY_EN
    check("parity_err", 32'(parity_err), 32'(m_perr));
`endif
    if (out_valid) begin
      if (exp_q.size() == 0) check("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
      else begin
        check("out_data", 32'(out_data), 32'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic cyc(bit v, bit s, bit f, bit d);
    @(posedge clk); #1;
    sin_valid = v; sin = s; sof = f; dir = d;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic send(logic [W-1:0] w, bit d, int gap);
    logic [W-1:0] x = w;
    for (int i = 0; i < W; i++) begin
      cyc(1, d ? x[W-1-i] : x[i], i == 0, d);
      if (gap > 0) idle(gap);
    end
`ifdef SERIAL_WORD_RX_PARITY_EN
    cyc(1, ^x, 0, d);
`endif
  endtask

  initial begin
    out_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    mon_en = 1;
    @(negedge clk);
    check("reset_out_data", 32'(out_data), 32'h0);
    // LSB-first 0,1,0,1 -> A; MSB-first with gaps -> C
    send(4'hA, 0, 0); idle(3);
    send(4'hC, 1, 3); idle(3);
    // overflow: 3 then 5 without ready, clear, then drain
    out_ready = 0;
    send(4'h3, 0, 0); idle(2);
    send(4'h5, 0, 0); idle(3);
    clr_ovf = 1; idle(1); clr_ovf = 0;
    out_ready = 1; idle(3);
    // mid-frame sof on bit 3 restarts frame: 1,0,0,0 -> 1
    cyc(1, 1, 1, 0); cyc(1, 0, 0, 0);
    send(4'h1, 0, 0); idle(3);
    // reset mid-frame then 1111
    cyc(1, 1, 1, 1); cyc(1, 0, 0, 1);
    @(posedge clk); #1 rst = 1; sin_valid = 0;
    @(posedge clk); #1 rst = 0;
    send(4'hF, 0, 0); idle(3);
`ifdef SERIAL_WORD_RX_PARITY_EN
    send(4'hA, 0, 0); idle(2);
    for (int i = 0; i < W; i++) cyc(1, (i % 2) == 1, i == 0, 0);
    cyc(1, 1, 0, 0); idle(3);
`endif
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      sin_valid = ($urandom_range(0, 9) < 6);
      sin       = 1'($urandom);
      sof       = ($urandom_range(0, W + 1) == 0);
      dir       = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      clr_ovf   = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 299) == 0);
    end
    @(posedge clk); #1;
    sin_valid = 0; sof = 0; rst = 0; clr_ovf = 0; out_ready = 1;
    idle(8);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    mon_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_word_rx.md
Name: serial_word_rx

Overview:
- Receive end of the serial link formed by shifting a parallel register out through its right-shift (LSB-first) or left-shift (MSB-first) path.
- Reassembles framed serial bits into WIDTH-bit words and presents them on a valid/ready output port.
- A one-word holding register decouples bit assembly from the downstream consumer.
- Sits between the serial line of a shifting register and the datapath that consumes parallel words.

Parameters:
- WIDTH, 4, data bits per word; legal range 2..16.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset
- sin_valid  in  1  sin carries a bit this cycle
- sin  in  1  serial data bit
- sof  in  1  qualifies sin_valid; marks the first bit of a frame
- dir  in  1  bit order, sampled with the sof bit; 0 = LSB first, 1 = MSB first
- out_ready  in  1  consumer accepts out_data
- clr_ovf  in  1  clears the overflow flag
- out_valid  out  1  out_data holds an unconsumed word
- out_data  out  WIDTH  assembled word
- busy  out  1  a frame is in progress (state != IDLE)
- overflow  out  1  sticky; a completed word was dropped
- frame_err  out  1  one-cycle pulse; a frame was aborted by a new sof

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: all state is cleared at the clk edge where rst=1, overriding every other input, including mid-frame.
  - state=IDLE, bit count=0, shift register=0, latched dir=0.
  - out_valid=0, out_data=0, overflow=0, frame_err=0, busy=0.
  - Any partial frame is discarded.
- States: IDLE, SHIFT, PAR (PAR exists only with the optional feature).
- IDLE:
  - Bits with sin_valid=1 and sof=0 are ignored.
  - sin_valid=1 and sof=1: latch dir, shift in sin, count=1, go to SHIFT.
- SHIFT:
  - Cycles with sin_valid=0 hold all state; gaps of any length are allowed.
  - sin_valid=1, sof=0: shift in sin, count++.
  - sin_valid=1, sof=1: pulse frame_err for one cycle, discard the partial word, restart as from IDLE with this bit as bit 1 and the newly sampled dir.
  - When the WIDTH-th bit is accepted, the word is complete: go to IDLE (or PAR with the feature).
- Shift rules:
  - dir=0: sreg <= {sin, sreg[WIDTH-1:1]}, so the first bit ends in bit 0.
  - dir=1: sreg <= {sreg[WIDTH-2:0], sin}, so the first bit ends in bit WIDTH-1.
  - No other arithmetic; count is $clog2(WIDTH+1) bits and never wraps past WIDTH.
- Delivery: on the cycle after the last bit is accepted, the word is offered to the holding register.
  - Holding register empty, or out_valid=1 with out_ready=1 that same cycle: the word loads and out_valid=1. Back-to-back words need no bubble.
  - out_valid=1 with out_ready=0: the word is dropped, out_data keeps the old word, overflow is set.
  - Latency: last data bit at edge N gives out_valid=1 after edge N+1.
- Output handshake:
  - A transfer occurs when out_valid=1 and out_ready=1.
  - out_valid falls after a transfer unless a new word loads in the same cycle.
  - out_data is stable while out_valid=1 and out_ready=0.
- overflow:
  - Cleared by clr_ovf.
  - If a set and clr_ovf occur in the same cycle, set wins.
- busy is registered: 1 in SHIFT and PAR.

Optional Feature:
- Macro: SERIAL_WORD_RX_PARITY_EN
- Defined:
  - After the WIDTH-th data bit, the FSM enters PAR and waits for one more sin_valid bit, the even-parity bit.
  - Match: deliver the word as above.
  - Mismatch: drop the word, leave overflow unchanged, pulse the extra output port parity_err (out, 1) for one cycle.
  - sof during PAR behaves as a mid-frame sof: frame_err pulses and the frame restarts.
- Not defined: no PAR state, no parity_err port; a word completes on its WIDTH-th bit.

Test Plan:
- WIDTH=4, dir=0, bits 0,1,0,1 (sof on the first) -> out_valid=1 one cycle after the 4th bit, out_data=4'hA, busy=0 afterwards.
- dir=1, bits 1,1,0,0 with 3 idle cycles between bits -> out_data=4'hC, no early out_valid during the gaps.
- Two frames 4'h3 then 4'h5 with out_ready=0 -> out_data stays 4'h3, overflow=1. Then clr_ovf=1 -> overflow=0. Then out_ready=1 -> one transfer, out_valid=0.
- sof asserted on the 3rd bit of a frame -> frame_err pulses once. The next 4 bits (starting with that one) form the word, e.g. 1,0,0,0 dir=0 -> 4'h1.
- rst=1 after 2 bits of a frame -> busy=0, out_valid=0. A following 4-bit frame 1,1,1,1 -> 4'hF.
- With SERIAL_WORD_RX_PARITY_EN defined: data 4'hA + parity 0 -> delivered. Data 4'hA + parity 1 -> parity_err pulse, out_valid stays 0.
